// File: rtl/instr_loader.sv
// Byte-stream program loader: LEN, (LEN+1) x {LO,HI}, CSUM -> one instruction RAM write per word, one cycle after its HI byte.
// Core released one cycle after a matching CSUM; in_ready is decoded from state only, so stalled bytes are never consumed.
module instr_loader #(
  parameter int AW = 8,
  parameter int IW = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_byte,
  output logic          in_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [IW-1:0] wr_data,
  output logic          core_reset,
  output logic          load_done,
  output logic          error
);

  typedef enum logic [2:0] {IDLE, HDR, LO, HI, WRITE, CSUM, DONE, ERR} state_t;

  state_t        state, nextState;
  logic [AW-1:0] len, cnt;
  logic [7:0]    lo, xorAcc;
  logic          hi;
  logic          xfer;

  assign xfer    = in_valid & in_ready;
  assign wr_addr = cnt;
  assign wr_data = IW'({hi, lo});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      len    <= '0;
      cnt    <= '0;
      lo     <= '0;
      hi     <= 1'b0;
      xorAcc <= '0;
    end else begin
      state <= nextState;
      case (state)
        IDLE, DONE, ERR: if (start) xorAcc <= '0;
        HDR: if (xfer) begin
          len    <= AW'(in_byte);
          cnt    <= '0;
          xorAcc <= xorAcc ^ in_byte;
        end
        LO: if (xfer) begin
          lo     <= in_byte;
          xorAcc <= xorAcc ^ in_byte;
        end
        HI: if (xfer && in_byte[7:1] == 7'd0) begin
          hi     <= in_byte[0];
          xorAcc <= xorAcc ^ in_byte;
        end
        // Compare before increment so a 256-word load stops at the last address.
        WRITE: if (cnt != len) cnt <= cnt + AW'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    nextState  = state;
    in_ready   = 1'b0;
    wr_en      = 1'b0;
    core_reset = 1'b1;
    load_done  = 1'b0;
    error      = 1'b0;
    case (state)
      IDLE: if (start) nextState = HDR;
      HDR: begin
        in_ready = 1'b1;
        if (xfer) nextState = LO;
      end
      LO: begin
        in_ready = 1'b1;
        if (xfer) nextState = HI;
      end
      HI: begin
        in_ready = 1'b1;
        if (xfer) nextState = (in_byte[7:1] != 7'd0) ? ERR : WRITE;
      end
      WRITE: begin
        wr_en     = 1'b1;
        nextState = (cnt == len) ? CSUM : LO;
      end
      CSUM: begin
        in_ready = 1'b1;
        if (xfer) nextState = (in_byte == xorAcc) ? DONE : ERR;
      end
      DONE: begin
        load_done  = 1'b1;
        core_reset = 1'b0;
        if (start) nextState = HDR;
      end
      ERR: begin
        error = 1'b1;
        if (start) nextState = HDR;
      end
      default: nextState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: expected writes queued at stimulus time, popped by a wr_en monitor.
module tb_instr_loader;

  logic       clk = 1'b0;
  logic       reset, start, in_valid;
  logic [7:0] in_byte;
  logic       in_ready, wr_en, core_reset, load_done, error;
  logic [7:0] wr_addr;
  logic [8:0] wr_data;

  typedef struct packed {logic [7:0] a; logic [8:0] d;} wr_t;

  wr_t        expQ[$];
  wr_t        monWr;
  logic [7:0] strm[$];
  int         tests = 0;
  int         fails = 0;
  int         writesSeen = 0;
  int         w0;

  instr_loader #(.AW(8), .IW(9)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .core_reset(core_reset), .load_done(load_done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      writesSeen++;
      check("wr_in_ready_low", {31'd0, in_ready}, 32'd0);
      if (expQ.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", wr_addr, wr_data);
      end else begin
        monWr = expQ.pop_front();
        check("wr_addr", {24'd0, wr_addr}, {24'd0, monWr.a});
        check("wr_data", {23'd0, wr_data}, {23'd0, monWr.d});
      end
    end
  end

  task automatic checkIdle(input string tag);
    check({tag, "_in_ready"},   {31'd0, in_ready},   32'd0);
    check({tag, "_wr_en"},      {31'd0, wr_en},      32'd0);
    check({tag, "_wr_addr"},    {24'd0, wr_addr},    32'd0);
    check({tag, "_wr_data"},    {23'd0, wr_data},    32'd0);
    check({tag, "_core_reset"}, {31'd0, core_reset}, 32'd1);
    check({tag, "_load_done"},  {31'd0, load_done},  32'd0);
    check({tag, "_error"},      {31'd0, error},      32'd0);
  endtask

  task automatic checkStatus(input string tag, input logic done, input logic err, input logic crst);
    check({tag, "_load_done"},  {31'd0, load_done},  {31'd0, done});
    check({tag, "_error"},      {31'd0, error},      {31'd0, err});
    check({tag, "_core_reset"}, {31'd0, core_reset}, {31'd0, crst});
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Holds the byte until a rising edge with in_ready high; returns 1 time unit after that edge.
  task automatic sendByte(input logic [7:0] b, input bit gaps);
    bit acc = 1'b0;
    int t = 0;
    if (gaps) repeat ($urandom_range(0, 3)) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_byte  = b;
    while (!acc && t < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      t++;
    end
    in_valid = 1'b0;
    if (!acc) check("sendByte_timeout", 32'd0, 32'd1);
  endtask

  task automatic sendStream(input bit gaps, input int first, input int last);
    for (int i = first; i <= last; i++) sendByte(strm[i], gaps);
  endtask

  // alt=0: word i = {i[0], i[7:0]}; alt=1: word i = {~i[0], i ^ A5}.
  task automatic buildProg(input int n, input bit alt, input logic [7:0] csumErr);
    logic [7:0] x, lb;
    logic       hb;
    strm.delete();
    x = 8'(n - 1);
    strm.push_back(x);
    for (int i = 0; i < n; i++) begin
      lb = alt ? (8'(i) ^ 8'hA5) : 8'(i);
      hb = alt ? ~i[0] : i[0];
      strm.push_back(lb);
      strm.push_back({7'd0, hb});
      x = x ^ lb ^ {7'd0, hb};
      expQ.push_back({8'(i), hb, lb});
    end
    strm.push_back(x ^ csumErr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checkIdle("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: single word 0x134, CSUM = 00^34^01 = 35
    pulseStart();
    strm = '{8'h00, 8'h34, 8'h01, 8'h35};
    expQ.push_back({8'h00, 9'h134});
    w0 = writesSeen;
    sendStream(1'b0, 0, 3);
    @(negedge clk);
    checkStatus("t1", 1'b1, 1'b0, 1'b0);
    check("t1_writes", writesSeen - w0, 32'd1);

    // 2: full 256-word program
    pulseStart();
    w0 = writesSeen;
    buildProg(256, 1'b0, 8'h00);
    sendStream(1'b0, 0, strm.size() - 1);
    @(negedge clk);
    checkStatus("t2", 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("t2_writes", writesSeen - w0, 32'd256);
    check("t2_pending", expQ.size(), 32'd0);

    // 3: bad second HI byte
    pulseStart();
    strm = '{8'h01, 8'h11, 8'h01, 8'h22, 8'h02};
    expQ.push_back({8'h00, 9'h111});
    w0 = writesSeen;
    sendStream(1'b0, 0, 4);
    @(negedge clk);
    checkStatus("t3", 1'b0, 1'b1, 1'b1);
    check("t3_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (2) @(negedge clk);
    check("t3_writes", writesSeen - w0, 32'd1);

    // 4: checksum off by one, then recovery
    pulseStart();
    buildProg(3, 1'b1, 8'h01);
    sendStream(1'b0, 0, strm.size() - 1);
    @(negedge clk);
    checkStatus("t4_bad", 1'b0, 1'b1, 1'b1);
    pulseStart();
    check("t4_restart_error", {31'd0, error}, 32'd0);
    check("t4_restart_ready", {31'd0, in_ready}, 32'd1);
    buildProg(2, 1'b1, 8'h00);
    sendStream(1'b0, 0, strm.size() - 1);
    @(negedge clk);
    checkStatus("t4_good", 1'b1, 1'b0, 1'b0);

    // 5: gappy in_valid on a 3-word load
    pulseStart();
    w0 = writesSeen;
    buildProg(3, 1'b1, 8'h00);
    sendStream(1'b1, 0, strm.size() - 1);
    @(negedge clk);
    checkStatus("t5", 1'b1, 1'b0, 1'b0);
    check("t5_writes", writesSeen - w0, 32'd3);

    // 6: start ignored mid-load, then reset after 2 of 4 words
    pulseStart();
    w0 = writesSeen;
    buildProg(4, 1'b1, 8'h00);
    sendStream(1'b0, 0, 3);
    pulseStart();
    @(negedge clk);
    check("t6_ignored_start_addr", {24'd0, wr_addr}, 32'd1);
    check("t6_ignored_start_ready", {31'd0, in_ready}, 32'd1);
    sendStream(1'b0, 4, 4);
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checkIdle("t6_async");
    @(negedge clk);
    checkIdle("t6_reset");
    check("t6_writes", writesSeen - w0, 32'd2);
    check("t6_pending", expQ.size(), 32'd2);
    expQ.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    pulseStart();
    strm = '{8'h00, 8'h34, 8'h01, 8'h35};
    expQ.push_back({8'h00, 9'h134});
    sendStream(1'b0, 0, 3);
    @(negedge clk);
    checkStatus("t6_reload", 1'b1, 1'b0, 1'b0);
    check("final_pending", expQ.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
